// File: rtl/uart_rx.sv
// uart_rx: 8-bit, LSB-first asynchronous serial receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_rx,
  output logic [7:0] O_data,
  output logic       O_valid,
  input  logic       I_ready,
  output logic       O_busy,
  output logic       O_frame_err,
  output logic       O_overrun,
  output logic       O_parity_err
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_too_small
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY    = 3'd5
`endif
  } state_t;

  // Handshake: a byte moves to the consumer on every I_clk edge where
  // O_valid & I_ready; O_data is stable while O_valid is high.

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          w_sample;
  logic          w_shift_en;
  logic          w_stop_sample;
  logic          w_busy;
  logic          w_par_ok;
  logic          r_stop_ok;
  logic          r_stop_bad;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_frame_err;
  logic          r_overrun;

  // Synchroniser resets high so leaving reset never looks like a start bit.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= I_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (!r_rx_s) w_next_state = S_START;
      S_START:     if (w_sample) w_next_state = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (w_sample && (r_bit_cnt == 3'd7)) w_next_state = S_PARITY;
      S_PARITY:    if (w_sample) w_next_state = S_STOP;
`else
      S_DATA:      if (w_sample && (r_bit_cnt == 3'd7)) w_next_state = S_STOP;
`endif
      S_STOP:      if (w_sample) w_next_state = r_rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (r_rx_s) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_sample      = 1'b0;
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      S_IDLE:      w_busy = 1'b0;
      S_WAIT_HIGH: w_busy = 1'b0;
      S_START:     w_sample = (r_cnt == HALF_LAST);
      S_DATA: begin
        w_sample   = (r_cnt == BIT_LAST);
        w_shift_en = (r_cnt == BIT_LAST);
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:    w_sample = (r_cnt == BIT_LAST);
`endif
      S_STOP: begin
        w_sample      = (r_cnt == BIT_LAST);
        w_stop_sample = (r_cnt == BIT_LAST);
      end
      default:     w_busy = 1'b0;
    endcase
  end

  // The baud counter restarts on every state change and at each sample point.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      if ((w_next_state != r_state) || w_sample || !w_busy) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + 1'b1;
      if (r_state != S_DATA) r_bit_cnt <= 3'd0;
      else if (w_sample)     r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_par_bad;
  logic r_parity_err;

  assign w_par_ok = ((^r_shift) == r_par_bit);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_par_bit    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_sample) r_par_bit <= r_rx_s;
      // A bad stop bit wins over a parity mismatch.
      r_par_bad    <= w_stop_sample & r_rx_s & ~w_par_ok;
      r_parity_err <= r_par_bad;
    end
  end

  assign O_parity_err = r_parity_err;
`else
  assign w_par_ok     = 1'b1;
  assign O_parity_err = 1'b0;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_stop_ok   <= 1'b0;
      r_stop_bad  <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= 8'd0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_stop_ok   <= w_stop_sample & r_rx_s & w_par_ok;
      r_stop_bad  <= w_stop_sample & ~r_rx_s;
      r_frame_err <= r_stop_bad;
      r_overrun   <= r_stop_ok & r_valid & ~I_ready;
      // A consumer taking the old byte in the delivery cycle frees the slot for the new one.
      if (r_stop_ok && (!r_valid || I_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
      end else if (r_valid && I_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign O_data      = r_data;
  assign O_valid     = r_valid;
  assign O_busy      = w_busy;
  assign O_frame_err = r_frame_err;
  assign O_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at 10 clocks per bit; a monitor pops expected bytes
// and counts error pulses while the main sequence checks counts, latency and reset behaviour.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0, n_frame = 0, n_over = 0, n_par = 0;
  int s_valid, s_frame, s_over, s_par;
  bit lat_armed = 1'b0;
  int lat_start = 0;
  logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_rx(rx),
    .O_data(data), .O_valid(valid), .I_ready(ready),
    .O_busy(busy), .O_frame_err(frame_err), .O_overrun(overrun),
    .O_parity_err(parity_err)
  );

  // Clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    if (frame_err === 1'b1)  n_frame++;
    if (overrun === 1'b1)    n_over++;
    if (parity_err === 1'b1) n_par++;
    if (valid === 1'b1 && ready === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", data);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", 32'(data), 32'(e));
      end
      if (lat_armed) begin
        check("t1_latency", cyc - lat_start - 1, 98);
        lat_armed = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ par_flip);
`endif
    bit_time(stop);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic snap();
    s_valid = n_valid; s_frame = n_frame; s_over = n_over; s_par = n_par;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(valid), 0);
    check({tag, "_data"},   32'(data), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_frame"},  32'(frame_err), 0);
    check({tag, "_over"},   32'(overrun), 0);
    check({tag, "_parity"}, 32'(parity_err), 0);
  endtask

  initial begin
    // Reset values
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // Test 1: back-to-back 0x55, 0xA3, with latency measured on the first
    snap();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    lat_armed = 1'b1;
    lat_start = cyc;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    idle(30);
    drain();
    check("t1_latency_seen", 32'(lat_armed), 0);
    check("t1_valid_cnt", n_valid - s_valid, 2);
    check("t1_frame_cnt", n_frame - s_frame, 0);
    check("t1_over_cnt", n_over - s_over, 0);

    // Test 2: consumer stalled, second byte overruns
    snap();
    ready = 1'b0;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(30);
    check("t2_valid_held", 32'(valid), 1);
    check("t2_data_held", 32'(data), 32'h12);
    check("t2_over_cnt", n_over - s_over, 1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_valid_dropped", 32'(valid), 0);
    check("t2_data_after", 32'(data), 32'h12);
    drain();
    check("t2_frame_cnt", n_frame - s_frame, 0);

    // Test 3: 3-clock glitch while idle
    snap();
    idle(5);
    rx = 1'b0;
    idle(3);
    check("t3_busy_in_start", 32'(busy), 1);
    rx = 1'b1;
    idle(9);
    check("t3_busy_low", 32'(busy), 0);
    idle(20);
    check("t3_valid_cnt", n_valid - s_valid, 0);
    check("t3_frame_cnt", n_frame - s_frame, 0);

    // Test 4: bad stop bit followed by a break, then a good frame
    snap();
    send_byte(8'hF0, 1'b0);
    idle(50);
    rx = 1'b1;
    idle(20);
    check("t4_frame_cnt", n_frame - s_frame, 1);
    check("t4_no_valid", n_valid - s_valid, 0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    idle(30);
    drain();
    check("t4_valid_cnt", n_valid - s_valid, 1);
    check("t4_frame_cnt_end", n_frame - s_frame, 1);

    // Test 5: reset during data bit 4
    snap();
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rx = 1'b0;
    idle(5);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5_in_reset");
    idle(3);
    rx = 1'b1;
    rst_n = 1'b1;
    idle(20);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(30);
    drain();
    check("t5_valid_cnt", n_valid - s_valid, 1);
    check("t5_frame_cnt", n_frame - s_frame, 0);
    check("t5_over_cnt", n_over - s_over, 0);

`ifdef UART_RX_PARITY_EN
    // Test 6: good parity then bad parity
    snap();
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    idle(30);
    drain();
    par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(30);
    check("t6_valid_cnt", n_valid - s_valid, 1);
    check("t6_parity_cnt", n_par - s_par, 1);
    check("t6_frame_cnt", n_frame - s_frame, 0);
`else
    check("parity_never_pulsed", n_par, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8 data bits, no parity, 1 stop bit, LSB first, line idle high.
- Companion to the top-level uart_tx path. Supplies host-to-FPGA control bytes to the Print Control / debug logic.
- Runs on a single system clock. Delivers each byte through a one-entry valid/ready holding register with framing and overrun error pulses.

Parameters:
- CLK_FREQ, 27_000_000, I_clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLKS_PER_BIT, (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, derived (localparam), 234 at defaults. Elaboration must fail if CLKS_PER_BIT < 4.
- HALF_BIT, CLKS_PER_BIT/2, derived (localparam), 117 at defaults.

Ports:
- I_clk  input  1  system clock.
- I_rst_n  input  1  asynchronous active-low reset.
- I_rx  input  1  serial line, asynchronous to I_clk.
- O_data  output  8  received byte, stable while O_valid=1.
- O_valid  output  1  holding register full.
- I_ready  input  1  consumer accepts; transfer occurs when O_valid & I_ready.
- O_busy  output  1  high in every state except IDLE and WAIT_HIGH.
- O_frame_err  output  1  1-cycle pulse: stop bit sampled 0.
- O_overrun  output  1  1-cycle pulse: byte completed while holding register still full.
- O_parity_err  output  1  1-cycle pulse; parity mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - Two-flop synchroniser on I_rx resets to 1, so a reset never produces a false start.
  - State resets to IDLE; bit counter 0; shift register 0.
  - All outputs reset to 0.
- All logic uses I_clk only. Only the synchronised rx value (rx_s) is used.
- Baud counter: counts 0..N-1; the "sample point" is the cycle where counter == N-1; the counter clears on every state change.
- IDLE: rx_s==0 -> START.
- START, N=HALF_BIT (mid start bit):
  - rx_s==0 -> DATA.
  - rx_s==1 -> IDLE (glitch rejected; no output, no error).
- DATA, N=CLKS_PER_BIT:
  - At each sample point, shift rx_s in at the MSB end (right shift), so the first bit lands in bit 0.
  - After the 8th sample -> STOP (or PARITY with the feature enabled).
- STOP, N=CLKS_PER_BIT:
  - rx_s==1: deliver the byte, -> IDLE.
  - rx_s==0: O_frame_err pulses in the next cycle, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then -> IDLE. A break condition produces exactly one frame error.
- Delivery, in the cycle after a good stop sample:
  - Holding register empty, or I_ready=1 in that same cycle: load O_data, O_valid=1.
  - Otherwise: O_overrun pulses; the new byte is dropped; held O_data and O_valid are unchanged.
- Handshake:
  - O_valid drops in the cycle after O_valid & I_ready, unless a delivery occurs in that same cycle; then it stays high with the new data.
  - I_ready while O_valid=0 has no effect.
- Latency: O_valid rises 3 + HALF_BIT + 9*CLKS_PER_BIT clocks after the first I_clk edge at which I_rx is low. This comprises 2 clocks of synchronisation, the baud counting, and 1 delivery register.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving half a bit later is caught. Supports continuous traffic up to +/-2% baud mismatch.
- Reset asserted mid-frame: immediate return to the reset values; the partial byte is lost and no error pulses.
- O_parity_err is tied to 0 without the optional feature.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state (N=CLKS_PER_BIT) is inserted between DATA and STOP; it samples an even-parity bit.
  - On mismatch, O_parity_err pulses in the cycle after the stop sample and the byte is discarded (no O_valid, no overrun).
  - A stop-bit error takes priority: only O_frame_err pulses.
- Undefined: 8N1 framing, PARITY state absent, O_parity_err constant 0.

Test Plan:
- All tests use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10, HALF_BIT=5), with I_ready held 1.
- Test 1: send 0x55 then 0xA3 back-to-back. Required: O_valid pulses twice with O_data=0x55, then 0xA3. The first O_valid comes exactly 98 clocks after the first start-edge sample. No error pulses.
- Test 2: I_ready=0; send 0x12 then 0x34. Required: O_valid=1 with O_data=0x12 held. O_overrun pulses once at the end of the second frame. Raising I_ready then drops O_valid with O_data still 0x12.
- Test 3: drive I_rx low for 3 clocks while idle. Required: return to IDLE, O_busy low again within 9 clocks, no O_valid and no errors.
- Test 4: frame 0xF0 with stop bit 0, line then held low for 50 clocks, then a good 0x0F frame. Required: exactly one O_frame_err pulse, no O_valid for 0xF0, and O_valid with 0x0F afterwards.
- Test 5: assert I_rst_n=0 during data bit 4 of a frame, release, then send 0x81. Required: all outputs 0 during reset, no error pulses, and next O_data=0x81.
- Test 6 (UART_RX_PARITY_EN): send 0x07 with parity 1 -> O_valid, O_data=0x07. Send 0x07 with parity 0 -> one O_parity_err pulse, no O_valid.
